// File: rtl/sar_adc_core.sv
// sar_adc_core: N-bit successive-approximation engine driving an external DAC/T&H.
// Define ADC_SETTLE_EN to split every bit into a SET and a DECIDE clock.
module sar_adc_core #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         soc,
    input  logic         cmp,
    output logic [N-1:0] dac,
    output logic         hold,
    output logic         eoc,
    output logic [N-1:0] x
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t        state;
    logic [IW-1:0] i;
    logic          s1, s2, s3;
    logic          start;
    logic          decide;
    logic [N-1:0]  resolved;
    logic [N-1:0]  next_trial;

    assign start = s2 & ~s3;

    // NOTE: soc comes from the bus side, so it passes two flops before any logic uses it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= soc;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Current trial with bit i resolved by the comparator, plus the next trial bit set.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        resolved    = dac;
        resolved[i] = cmp;
        next_trial  = resolved;
        if (i != '0) begin
            next_trial[i - 1'b1] = 1'b1;
        end
    end

`ifdef ADC_SETTLE_EN
    logic phase;

    // phase 0 = SET (DAC settling, cmp ignored), phase 1 = DECIDE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= 1'b0;
        end else if (state == IDLE) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
        end
    end

    assign decide = phase;
`else
    assign decide = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            i     <= IW'(N - 1);
            dac   <= '0;
            hold  <= 1'b0;
            eoc   <= 1'b1;
            x     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CONV;
                        eoc   <= 1'b0;
                        hold  <= 1'b1;
                        dac   <= {1'b1, {(N-1){1'b0}}};
                        i     <= IW'(N - 1);
                    end
                end
                CONV: begin
                    if (decide) begin
                        if (i != '0) begin
                            dac <= next_trial;
                            i   <= i - 1'b1;
                        end else begin
                            x     <= resolved;
                            eoc   <= 1'b1;
                            hold  <= 1'b0;
                            dac   <= '0;
                            i     <= IW'(N - 1);
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
